// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage ARM pipeline: operand forwarding, load-use stall,
// branch stall/flush, and saturating stall/branch event counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic             RegWriteCondE,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] BranchCount
);

  localparam logic [3:0] PC_REG = 4'd15;

  logic [3:0]       wa3m_q, wa3m_d, wa3w_q, wa3w_d;
  logic             regwritem_q, regwritem_d, regwritew_q, regwritew_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, branch_cnt_q, branch_cnt_d;

  logic             ldr_stall;
  logic             pc_wr_pending;
  logic [3:0]       ra_e [2];
  logic [1:0]       fwd  [2];

  assign ra_e[0] = RA1E;
  assign ra_e[1] = RA2E;

  // Load-use check uses the ungated MemtoRegE, so it may stall for a squashed load.
  assign ldr_stall     = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

  // One forwarding selector per E-stage source operand; M beats W, R15 never forwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (ra_e[gi] != PC_REG) begin
          if (regwritem_q && (ra_e[gi] == wa3m_q)) begin
            fwd[gi] = 2'b10;
          end else if (regwritew_q && (ra_e[gi] == wa3w_q)) begin
            fwd[gi] = 2'b01;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd[0];
      ForwardBE = fwd[1];
      StallD    = ldr_stall;
      FlushE    = ldr_stall;
      StallF    = ldr_stall | pc_wr_pending;
      FlushD    = pc_wr_pending | PCSrcW;
    end
  end

  always_comb begin
    wa3m_d       = wa3m_q;
    regwritem_d  = regwritem_q;
    wa3w_d       = wa3w_q;
    regwritew_d  = regwritew_q;
    stall_cnt_d  = stall_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (Enable) begin
      wa3m_d      = WA3E;
      regwritem_d = RegWriteCondE;
      wa3w_d      = wa3m_q;
      regwritew_d = regwritem_q;
      if (ldr_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (PCSrcW && (branch_cnt_q != {CNT_W{1'b1}})) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wa3m_q       <= 4'd0;
      regwritem_q  <= 1'b0;
      wa3w_q       <= 4'd0;
      regwritew_q  <= 1'b0;
      stall_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      wa3m_q       <= wa3m_d;
      regwritem_q  <= regwritem_d;
      wa3w_q       <= wa3w_d;
      regwritew_q  <= regwritew_d;
      stall_cnt_q  <= stall_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign BranchCount = branch_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model of the pipeline write history.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset, Enable;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E;
  logic        RegWriteCondE, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount, BranchCount;

  int checks = 0;
  int failures = 0;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Enable(Enable),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWriteCondE(RegWriteCondE), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .BranchCount(BranchCount)
  );

  always #5 clk = ~clk;

  // Reference model: the destinations written by the last two instructions that left E.
  logic [3:0] hist_wa [2] = '{4'd0, 4'd0};
  logic       hist_we [2] = '{1'b0, 1'b0};
  int         ref_stalls = 0;
  int         ref_branches = 0;

  function automatic logic ref_ldr();
    return MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (reset || ra == 4'd15) return 2'b00;
    if (hist_we[0] && ra == hist_wa[0]) return 2'b10;
    if (hist_we[1] && ra == hist_wa[1]) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist_wa      <= '{4'd0, 4'd0};
      hist_we      <= '{1'b0, 1'b0};
      ref_stalls   <= 0;
      ref_branches <= 0;
    end else if (Enable) begin
      hist_wa      <= '{WA3E, hist_wa[0]};
      hist_we      <= '{RegWriteCondE, hist_we[0]};
      ref_stalls   <= (ref_ldr() && ref_stalls < 65535) ? ref_stalls + 1 : ref_stalls;
      ref_branches <= (PCSrcW && ref_branches < 65535) ? ref_branches + 1 : ref_branches;
    end
  end

  task automatic clr_in();
    reset = 1'b0; Enable = 1'b1;
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0; WA3E = 4'd0;
    RegWriteCondE = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    RA1E = 4'd1; RA2E = 4'd1; WA3E = 4'd1; MemtoRegE = 1'b1; RA1D = 4'd1;
    PCSrcD = 1'b1; PCSrcW = 1'b1; RegWriteCondE = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE});
    end
    @(negedge clk);
    #1;
    checks++;
    if (StallCount !== 16'd0 || BranchCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", StallCount, BranchCount);
    end
    clr_in();
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      failures++;
      $display("FAIL reset_no_fwd: got %b required 00", ForwardAE);
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_forward_mw();
    do_reset();
    clr_in(); WA3E = 4'd1; RegWriteCondE = 1'b1;
    @(negedge clk);
    clr_in(); RA1E = 4'd1; WA3E = 4'd5;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      failures++; $display("FAIL fwd_from_m: got %b required 10", ForwardAE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      failures++; $display("FAIL fwd_from_w: got %b required 01", ForwardAE);
    end
    @(negedge clk);
    $display("test_forward_mw done");
  endtask

  task automatic test_priority_r15();
    do_reset();
    clr_in(); WA3E = 4'd3; RegWriteCondE = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_in(); RA2E = 4'd3;
    #1;
    checks++;
    if (ForwardBE !== 2'b10) begin
      failures++; $display("FAIL fwd_m_priority: got %b required 10", ForwardBE);
    end
    WA3E = 4'd15; RegWriteCondE = 1'b1;
    @(negedge clk);
    clr_in(); RA1E = 4'd15;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      failures++; $display("FAIL fwd_r15: got %b required 00", ForwardAE);
    end
    WA3E = 4'd6;
    @(negedge clk);
    clr_in(); RA1E = 4'd6;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      failures++; $display("FAIL fwd_cond_fail_m: got %b required 00", ForwardAE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      failures++; $display("FAIL fwd_cond_fail_w: got %b required 00", ForwardAE);
    end
    @(negedge clk);
    $display("test_priority_r15 done");
  endtask

  task automatic test_load_use();
    do_reset();
    clr_in(); MemtoRegE = 1'b1; WA3E = 4'd4; RegWriteCondE = 1'b1; RA2D = 4'd4; RA1D = 4'd7;
    #1;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110 || StallCount !== 16'd0) begin
      failures++;
      $display("FAIL load_use_stall: got F/D/E/FD=%b cnt=%0d required 1110 cnt=0",
               {StallF, StallD, FlushE, FlushD}, StallCount);
    end
    @(negedge clk);
    clr_in(); RA2D = 4'd4;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000 || StallCount !== 16'd1 || ForwardBE !== 2'b00) begin
      failures++;
      $display("FAIL load_use_release: got stalls=%b cnt=%0d fwdB=%b required 000 cnt=1 fwdB=00",
               {StallF, StallD, FlushE}, StallCount, ForwardBE);
    end
    @(negedge clk);
    clr_in(); RA2E = 4'd4;
    #1;
    checks++;
    if (ForwardBE !== 2'b01) begin
      failures++; $display("FAIL load_use_fwd_w: got %b required 01", ForwardBE);
    end
    @(negedge clk);
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clr_in();
      PCSrcD = (k == 0); PCSrcE = (k == 1); PCSrcM = (k == 2); PCSrcW = (k == 3);
      #1;
      checks++;
      if (StallF !== (k < 3) || FlushD !== 1'b1 || BranchCount !== 16'd0) begin
        failures++;
        $display("FAIL branch_cycle%0d: got StallF=%b FlushD=%b cnt=%0d required %b 1 0",
                 k, StallF, FlushD, BranchCount, (k < 3));
      end
      @(negedge clk);
    end
    clr_in();
    #1;
    checks++;
    if (BranchCount !== 16'd1 || FlushD !== 1'b0 || StallF !== 1'b0) begin
      failures++;
      $display("FAIL branch_count: got cnt=%0d FlushD=%b StallF=%b required 1 0 0",
               BranchCount, FlushD, StallF);
    end
    @(negedge clk);
    $display("test_branch done");
  endtask

  task automatic test_enable();
    do_reset();
    clr_in(); WA3E = 4'd9; RegWriteCondE = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      clr_in(); Enable = 1'b0;
      WA3E = 4'(10 + k); RegWriteCondE = 1'b1; MemtoRegE = 1'b1; RA1D = WA3E; PCSrcW = 1'b1;
      @(negedge clk);
    end
    clr_in(); Enable = 1'b0; RA1E = 4'd9;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || StallCount !== 16'd0 || BranchCount !== 16'd0) begin
      failures++;
      $display("FAIL enable_hold: got fwdA=%b cnt=%0d/%0d required 10 0/0",
               ForwardAE, StallCount, BranchCount);
    end
    Enable = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      failures++; $display("FAIL enable_resume: got %b required 01", ForwardAE);
    end
    @(negedge clk);
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    clr_in(); WA3E = 4'd2; RegWriteCondE = 1'b1; PCSrcW = 1'b1;
    @(negedge clk);
    clr_in(); reset = 1'b1; RA1E = 4'd2; MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    PCSrcD = 1'b1; PCSrcW = 1'b1;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b required 00000000",
               {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE});
    end
    @(negedge clk);
    clr_in(); RA1E = 4'd2;
    #1;
    checks++;
    if (ForwardAE !== 2'b00 || StallCount !== 16'd0 || BranchCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_after: got fwdA=%b cnt=%0d/%0d required 00 0/0",
               ForwardAE, StallCount, BranchCount);
    end
    @(negedge clk);
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    do_reset();
    clr_in(); MemtoRegE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
    repeat (65534) @(negedge clk);
    #1;
    checks++;
    if (StallCount !== 16'hFFFE) begin
      failures++; $display("FAIL sat_pre: got %h required fffe", StallCount);
    end
    @(negedge clk);
    #1;
    checks++;
    if (StallCount !== 16'hFFFF) begin
      failures++; $display("FAIL sat_reach: got %h required ffff", StallCount);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (StallCount !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold: got %h required ffff", StallCount);
    end
    clr_in();
    @(negedge clk);
    $display("test_saturation done");
  endtask

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic exp_ldr, exp_pc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 29) == 0);
      Enable = ($urandom_range(0, 4) != 0);
      RA1D = pick_reg(); RA2D = pick_reg(); RA1E = pick_reg(); RA2E = pick_reg();
      WA3E = pick_reg();
      RegWriteCondE = 1'($urandom); MemtoRegE = 1'($urandom);
      PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
      PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 3) == 0);
      #1;
      exp_ldr = !reset && ref_ldr();
      exp_pc  = !reset && (PCSrcD || PCSrcE || PCSrcM);
      checks++;
      if (ForwardAE !== ref_fwd(RA1E) || ForwardBE !== ref_fwd(RA2E)) begin
        failures++;
        $display("FAIL rand_fwd[%0d]: got A=%b B=%b required A=%b B=%b",
                 n, ForwardAE, ForwardBE, ref_fwd(RA1E), ref_fwd(RA2E));
      end
      checks++;
      if (StallD !== exp_ldr || FlushE !== exp_ldr || StallF !== (exp_ldr || exp_pc) ||
          FlushD !== (exp_pc || (!reset && PCSrcW))) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got F/D/FD/FE=%b%b%b%b required %b%b%b%b", n,
                 StallF, StallD, FlushD, FlushE, exp_ldr || exp_pc, exp_ldr,
                 exp_pc || (!reset && PCSrcW), exp_ldr);
      end
      checks++;
      if (StallCount !== 16'(ref_stalls) || BranchCount !== 16'(ref_branches)) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d required %0d/%0d",
                 n, StallCount, BranchCount, ref_stalls, ref_branches);
      end
      @(negedge clk);
    end
    clr_in();
    $display("test_random done");
  endtask

  initial begin
    clr_in();
    @(negedge clk);
    test_reset();
    test_forward_mw();
    test_priority_r15();
    test_load_use();
    test_branch();
    test_enable();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
